// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter slice.
// Widths, master indices, active-low levels and a grant decode helper.
package bus_arbiter_pkg;

    localparam int WORD_W      = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int MASTERS     = 4;
    localparam int OWNER_W     = 2;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_CYC = 255;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [OWNER_W-1:0] IF_MASTER  = 2'd0;
    localparam logic [OWNER_W-1:0] MEM_MASTER = 2'd1;

    // Active-low one-hot grant for a given owner index.
    function automatic logic [MASTERS-1:0] grant_vec(
        input logic [OWNER_W-1:0] idx
    );
        return ~(MASTERS'(1) << idx);
    endfunction

endpackage

// File: rtl/rr_next_owner.sv
// Rotate-priority encoder: picks the next bus owner from active-low requests.
// Ports: req_ (per-master request), owner (current) -> next_owner, valid.
module rr_next_owner
    import bus_arbiter_pkg::*;
(
    input  logic [MASTERS-1:0] req_,
    input  logic [OWNER_W-1:0] owner,
    output logic [OWNER_W-1:0] next_owner,
    output logic               valid
);

    logic [OWNER_W-1:0] cand;

    always_comb begin
        next_owner = owner;
        valid      = 1'b0;
        cand       = owner;
        if (req_[owner] == ENABLE_) begin
            valid = 1'b1;
        end else begin
            // Walk from farthest to nearest so the nearest requester wins.
            for (int k = MASTERS - 1; k >= 1; k--) begin
                cand = owner + OWNER_W'(k);
                if (req_[cand] == ENABLE_) begin
                    next_owner = cand;
                    valid      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with bus parking, owner mux and rdy_ watchdog.
// Ports: clk, reset (sync active-low), m_* master side, s_* bus side, owner, bus_timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = WORD_ADDR_W,
    parameter int DATA_W  = WORD_W,
    parameter int TIMEOUT = TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MASTERS-1:0]        m_req_,
    input  logic [MASTERS*ADDR_W-1:0] m_addr,
    input  logic [MASTERS-1:0]        m_as_,
    input  logic [MASTERS-1:0]        m_rw,
    input  logic [MASTERS*DATA_W-1:0] m_wr_data,
    output logic [MASTERS-1:0]        m_grnt_,
    output logic [ADDR_W-1:0]         s_addr,
    output logic                      s_as_,
    output logic                      s_rw,
    output logic [DATA_W-1:0]         s_wr_data,
    input  logic                      s_rdy_,
    output logic [OWNER_W-1:0]        owner,
    output logic                      bus_timeout
);

    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [OWNER_W-1:0] arb_owner;
    logic [OWNER_W-1:0] owner_d;
    logic               arb_valid;
    logic               waiting;
    logic               expired;
    logic               hold;

    rr_next_owner u_rr (
        .req_       (m_req_),
        .owner      (owner),
        .next_owner (arb_owner),
        .valid      (arb_valid)
    );

    assign s_addr    = m_addr[32'(owner) * ADDR_W +: ADDR_W];
    assign s_wr_data = m_wr_data[32'(owner) * DATA_W +: DATA_W];
    assign s_rw      = m_rw[owner];
    assign s_as_     = m_as_[owner];

    assign waiting     = (s_as_ == ENABLE_) && (s_rdy_ == DISABLE_);
    assign expired     = (wait_cnt == TO_C);
    // An expired watchdog releases the bus for one arbitration slot.
    assign hold        = waiting && !expired;
    assign bus_timeout = expired;

    always_comb begin
        owner_d = owner;
        cnt_d   = wait_cnt + CNT_W'(1);
        if (!hold && arb_valid) begin
            owner_d = arb_owner;
        end
        if (expired || !waiting || (owner_d != owner)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner    <= IF_MASTER;
            m_grnt_  <= grant_vec(IF_MASTER);
            wait_cnt <= '0;
        end else begin
            owner    <= owner_d;
            m_grnt_  <= grant_vec(owner_d);
            wait_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic.
// A cycle-level reference model tracks owner and watchdog count.
module tb_bus_arbiter;

    localparam int M  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic [M-1:0]    m_req_;
    logic [M*AW-1:0] m_addr;
    logic [M-1:0]    m_as_;
    logic [M-1:0]    m_rw;
    logic [M*DW-1:0] m_wr_data;
    logic [M-1:0]    m_grnt_;
    logic [AW-1:0]   s_addr;
    logic            s_as_;
    logic            s_rw;
    logic [DW-1:0]   s_wr_data;
    logic            s_rdy_;
    logic [1:0]      owner;
    logic            bus_timeout;

    int vectors = 0;
    int errors  = 0;
    int m_owner = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .m_req_      (m_req_),
        .m_addr      (m_addr),
        .m_as_       (m_as_),
        .m_rw        (m_rw),
        .m_wr_data   (m_wr_data),
        .m_grnt_     (m_grnt_),
        .s_addr      (s_addr),
        .s_as_       (s_as_),
        .s_rw        (s_rw),
        .s_wr_data   (s_wr_data),
        .s_rdy_      (s_rdy_),
        .owner       (owner),
        .bus_timeout (bus_timeout)
    );

    // Model one clock edge using the rules: hold while owner requests,
    // otherwise rotate; frozen during an unexpired in-flight access.
    task automatic tick();
        int  nxt_owner;
        int  nxt_cnt;
        bit  in_flight;
        bit  to;
        bit  found;
        to        = (m_cnt == TO);
        in_flight = (m_as_[m_owner] == 1'b0) && (s_rdy_ == 1'b1);
        nxt_owner = m_owner;
        found     = 1'b0;
        if (!(in_flight && !to) && m_req_[m_owner]) begin
            for (int k = 1; k < M; k++) begin
                if (!found && !m_req_[(m_owner + k) % M]) begin
                    nxt_owner = (m_owner + k) % M;
                    found     = 1'b1;
                end
            end
        end
        if (to || !in_flight || nxt_owner != m_owner) nxt_cnt = 0;
        else nxt_cnt = m_cnt + 1;
        if (!reset) begin
            nxt_owner = 0;
            nxt_cnt   = 0;
        end
        @(posedge clk);
        #1;
        m_owner = nxt_owner;
        m_cnt   = nxt_cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_req_ = 4'b1111; m_as_ = 4'b1111; m_rw = 4'b0000;
        s_rdy_ = 1'b1; m_addr = '0; m_wr_data = '0;
        tick(); tick();
        vectors++;
        if (m_grnt_ !== 4'b1110) begin
            errors++;
            $display("FAIL reset_grnt got=%b want=1110", m_grnt_);
        end
        vectors++;
        if (owner !== 2'd0 || bus_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_owner got=%0d/%b want=0/0", owner, bus_timeout);
        end
        reset = 1'b1;
        tick(); tick();
        vectors++;
        if (owner !== 2'd0 || m_grnt_ !== 4'b1110) begin
            errors++;
            $display("FAIL reset_hold got=%0d/%b want=0/1110", owner, m_grnt_);
        end
    endtask

    task automatic test_park_grant();
        for (int i = 0; i < M; i++) m_addr[i*AW +: AW] = AW'(32'h100 * (i + 1));
        m_req_ = 4'b1101;
        tick();
        vectors++;
        if (owner !== 2'd1 || m_grnt_ !== 4'b1101) begin
            errors++;
            $display("FAIL park_grant got=%0d/%b want=1/1101", owner, m_grnt_);
        end
        #1;
        vectors++;
        if (s_addr !== AW'(32'h200)) begin
            errors++;
            $display("FAIL park_addr got=%h want=200", s_addr);
        end
    endtask

    task automatic test_rotation();
        int want [3] = '{2, 3, 0};
        logic [M-1:0] rel [3] = '{4'b0010, 4'b0110, 4'b1110};
        m_req_ = 4'b0000;
        tick(); tick(); tick();
        vectors++;
        if (owner !== 2'd1) begin
            errors++;
            $display("FAIL rot_hold got=%0d want=1", owner);
        end
        for (int i = 0; i < 3; i++) begin
            m_req_ = rel[i];
            tick();
            vectors++;
            if (int'(owner) != want[i] || m_grnt_ !== ~(4'b1 << want[i])) begin
                errors++;
                $display("FAIL rot_step%0d got=%0d/%b want=%0d", i, owner, m_grnt_, want[i]);
            end
        end
    endtask

    task automatic test_inflight_block();
        m_req_ = 4'b1101;
        tick();
        m_as_  = 4'b1101;
        s_rdy_ = 1'b1;
        m_req_ = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (owner !== 2'd1 || int'(owner) != m_owner) begin
                errors++;
                $display("FAIL inflight_hold c%0d got=%0d want=1", i, owner);
            end
        end
        s_rdy_ = 1'b0;
        tick();
        vectors++;
        if (owner !== 2'd2 || m_grnt_ !== 4'b1011) begin
            errors++;
            $display("FAIL inflight_switch got=%0d/%b want=2/1011", owner, m_grnt_);
        end
        m_as_ = 4'b1111;
        s_rdy_ = 1'b1;
        m_req_ = 4'b1110;
        tick();
        vectors++;
        if (owner !== 2'd0) begin
            errors++;
            $display("FAIL inflight_back got=%0d want=0", owner);
        end
    endtask

    task automatic test_watchdog();
        m_req_ = 4'b1011;
        m_as_  = 4'b1110;
        s_rdy_ = 1'b1;
        for (int i = 1; i < TO; i++) begin
            tick();
            if (bus_timeout !== 1'b0 || owner !== 2'd0) begin
                vectors++;
                errors++;
                $display("FAIL wd_early c%0d got=%b/%0d want=0/0", i, bus_timeout, owner);
            end
        end
        vectors++;
        tick();
        vectors++;
        if (bus_timeout !== 1'b1 || owner !== 2'd0 || m_cnt != TO) begin
            errors++;
            $display("FAIL wd_pulse got=%b/%0d want=1/0", bus_timeout, owner);
        end
        tick();
        vectors++;
        if (bus_timeout !== 1'b0 || owner !== 2'd2) begin
            errors++;
            $display("FAIL wd_after got=%b/%0d want=0/2", bus_timeout, owner);
        end
        m_as_ = 4'b1111;
    endtask

    task automatic test_reset_mid();
        m_req_ = 4'b0111;
        tick();
        m_as_  = 4'b0111;
        s_rdy_ = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        vectors++;
        if (owner !== 2'd3 || m_cnt != 100) begin
            errors++;
            $display("FAIL mid_setup got=%0d want=3", owner);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if (owner !== 2'd0 || m_grnt_ !== 4'b1110 || bus_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%0d/%b/%b want=0/1110/0", owner, m_grnt_, bus_timeout);
        end
        // Owner 0 now strobes: pulse must need a full fresh wait.
        m_req_ = 4'b1111;
        m_as_  = 4'b1110;
        for (int i = 1; i <= TO + 1; i++) begin
            tick();
            vectors++;
            if (bus_timeout !== (i == TO)) begin
                errors++;
                $display("FAIL mid_wd c%0d got=%b want=%b", i, bus_timeout, i == TO);
            end
        end
        m_as_ = 4'b1111;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            m_req_    = 4'($urandom);
            m_as_     = 4'($urandom);
            m_rw      = 4'($urandom);
            s_rdy_    = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 60) != 0);
            m_addr    = {$urandom, $urandom, $urandom, $urandom};
            m_wr_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            vectors++;
            if (s_addr !== m_addr[m_owner*AW +: AW] || s_as_ !== m_as_[m_owner]
                || s_rw !== m_rw[m_owner]
                || s_wr_data !== m_wr_data[m_owner*DW +: DW]) begin
                errors++;
                $display("FAIL rnd_mux n%0d got=%h/%b/%b want_owner=%0d",
                         n, s_addr, s_as_, s_rw, m_owner);
            end
            tick();
            vectors++;
            if (int'(owner) != m_owner || m_grnt_ !== ~(4'b1 << m_owner)
                || bus_timeout !== (m_cnt == TO)) begin
                errors++;
                $display("FAIL rnd_state n%0d got=%0d/%b/%b want=%0d",
                         n, owner, m_grnt_, bus_timeout, m_owner);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_park_grant();
        test_rotation();
        test_inflight_block();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus; the CPU's IF and MEM stage masters (plus up to two further masters) compete for it.
- Owns the active-low req_/grnt_ handshake per master and multiplexes the granted master's addr/as_/rw/wr_data onto the shared bus.
- Carries a bus-wait watchdog that flags a slave that never returns rdy_.
- Sits between the CPU_top bus ports and the bus slaves/address decoder.

Parameters:
- MASTERS, 4, number of bus masters (fixed 4 this revision; index 0 = IF, 1 = MEM).
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles a strobed access may wait for rdy_ before the watchdog fires (8-bit counter).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous active-low reset.
- m_req_  in  MASTERS  per-master bus request, active-low.
- m_addr  in  MASTERS*ADDR_W  per-master address, master i in bits [i*ADDR_W +: ADDR_W].
- m_as_  in  MASTERS  per-master address strobe, active-low.
- m_rw  in  MASTERS  per-master read(1)/write(0).
- m_wr_data  in  MASTERS*DATA_W  per-master write data.
- m_grnt_  out  MASTERS  per-master grant, active-low, one-hot-low.
- s_addr  out  ADDR_W  shared-bus address.
- s_as_  out  1  shared-bus strobe, active-low.
- s_rw  out  1  shared-bus read/write.
- s_wr_data  out  DATA_W  shared-bus write data.
- s_rdy_  in  1  slave ready, active-low.
- owner  out  2  index of the current bus owner.
- bus_timeout  out  1  one-cycle pulse when the watchdog expires.

Behaviour:

Reset (reset==0 at posedge):
- owner=0, m_grnt_=4'b1110, wait counter=0, bus_timeout=0.

Grant model (bus parking):
- Exactly one master is always granted.
- m_grnt_ is registered and always equals ~(1<<owner).

Arbitration, evaluated each posedge:
- If m_req_[owner]==0: owner is unchanged (the grant is held for back-to-back accesses).
- Otherwise, search m_req_ for the first low bit in order owner+1, owner+2, owner+3 (mod 4). The winner becomes owner next cycle.
- If no master is requesting, owner is unchanged.
- Grant latency: a requester is granted at most 1 cycle after the owner releases its request. A request from a non-owner while the bus is idle and parked is therefore granted on the next posedge.
- Owner switch is blocked while s_as_==0 && s_rdy_==1 (access in flight). Arbitration resumes the cycle after rdy_ returns or the strobe drops.
- Simultaneous requests are resolved purely by rotation from the current owner. A master releasing and another requesting in the same cycle hands over in one cycle.

Mux (combinational from the registered owner):
- s_addr, s_rw and s_wr_data follow the owner's inputs; s_as_ = m_as_[owner].
- A non-owner's as_ never reaches the bus.

Watchdog:
- Counter clears whenever s_as_==1 or s_rdy_==0, and on an owner change. Otherwise it increments.
- On count==TIMEOUT: bus_timeout=1 for exactly one cycle, counter clears, and owner arbitration is unblocked for that cycle.
- Counter saturates-free: it never exceeds TIMEOUT.

Reset mid-operation:
- Synchronous reset overrides everything in the same posedge (owner=0, pulse dropped, counter cleared), including during an in-flight access.

Decomposition:
- Shared package/header holds: WORD/WORD_ADDR_W widths, MASTERS, OWNER_W=2, ENABLE_/DISABLE_ active-low constants, master index constants IF_MASTER=0 and MEM_MASTER=1.
- One natural sub-module: rr_next_owner (combinational rotate-priority encoder: req_ vector + owner -> next owner, valid).
- The owner register, watchdog and mux stay in bus_arbiter.

Test Plan:
1. Reset low for 2 cycles, all req_ high -> m_grnt_=4'b1110, owner=0, bus_timeout=0; state holds after release.
2. Owner 0 idle, m_req_=4'b1101 -> next posedge owner=1, m_grnt_=4'b1101; s_addr tracks m_addr of master 1.
3. m_req_=4'b0000 held from owner=1 -> owner stays 1. Release master 1 -> owner 2, then 3, then 0 on successive releases (rotation 2,3,0).
4. Owner 1 with s_as_=0, s_rdy_=1 for 10 cycles while master 1 drops req_ and master 2 requests -> owner stays 1 until s_rdy_=0, then switches to 2 one cycle later.
5. Owner 0 strobes with s_rdy_ held high -> bus_timeout pulses exactly at cycle 255 of the wait; with m_req_[2]=0 pending, owner=2 the next cycle.
6. Reset asserted mid-access (owner=3, counter=100) -> next posedge owner=0, counter=0, no bus_timeout pulse.
